// File: rtl/usb4_lane_block_encoder.sv
// usb4_lane_block_encoder
//   Multi-lane USB4 transmit block encoder. Collects one byte per lane per
//   accepted cycle into 64b/66b (gen_speed=2) or 128b/132b (gen_speed=1)
//   blocks and prepends the sync header, or passes single bytes through
//   (gen_speed=0). One output register plus one holding block (the
//   accumulator itself) keep intake running across a one-block serializer stall.
// Ports:
//   enc_clk, rst (async, active low), enable (low = synchronous flush)
//   gen_speed, d_sel, in_valid/in_ready, lane_tx[8*NUM_LANES]  byte intake
//   out_data[132*NUM_LANES], out_type, out_valid/out_ready     block output
//   new_sym, enable_ser, mode_err                              status

// Per-lane datapath: byte accumulator and formatted output register.
module usb4_lbe_lane (
  input  logic         enc_clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [7:0]   byte_in,
  input  logic         first,
  input  logic [3:0]   pos,
  input  logic         acc_wr,
  input  logic         out_ld,
  input  logic         out_sel_held,
  input  logic [1:0]   fmt_mode,
  input  logic         fmt_type,
  output logic [131:0] blk_out
);
  logic [127:0] acc_q, acc_d, blk_data, fmt_src;
  logic [131:0] out_q, out_d, fmt_blk;

  always_comb begin
    // A new block starts from zero so stale bytes of a longer mode never leak.
    blk_data = first ? '0 : acc_q;
    blk_data[{pos, 3'b000} +: 8] = byte_in;
    fmt_src = out_sel_held ? acc_q : blk_data;
    case (fmt_mode)
      2'd1:    fmt_blk = {(fmt_type ? 4'b0101 : 4'b1010), fmt_src};
      2'd2:    fmt_blk = {66'd0, (fmt_type ? 2'b01 : 2'b10), fmt_src[63:0]};
      default: fmt_blk = {124'd0, fmt_src[7:0]};
    endcase
    acc_d = flush ? '0 : (acc_wr ? blk_data : acc_q);
    out_d = out_ld ? fmt_blk : out_q;
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      out_q <= '0;
    end else begin
      acc_q <= acc_d;
      out_q <= out_d;
    end
  end

  assign blk_out = out_q;
endmodule

module usb4_lane_block_encoder #(
  parameter int NUM_LANES      = 2,
  parameter int TRANSPORT_DSEL = 8,
  parameter int IDLE_DSEL      = 9
) (
  input  logic                       enc_clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 gen_speed,
  input  logic [3:0]                 d_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*NUM_LANES-1:0]     lane_tx,
  output logic [132*NUM_LANES-1:0]   out_data,
  output logic                       out_type,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       new_sym,
  output logic                       enable_ser,
  output logic                       mode_err
);
  localparam logic [3:0] TDSEL = 4'(TRANSPORT_DSEL);
  localparam logic [3:0] IDSEL = 4'(IDLE_DSEL);

  logic [3:0] cnt_q, cnt_d, eff_cnt, blk_last;
  logic [1:0] gen_q, gen_d, fmt_mode;
  logic       type_q, type_d, cur_type, fmt_type;
  logic       acc_full_q, acc_full_d;
  logic       out_valid_q, out_valid_d;
  logic       out_type_q, out_type_d;
  logic       new_sym_q, new_sym_d;
  logic       enable_ser_q, enable_ser_d;
  logic       mode_err_q, mode_err_d;
  logic       mode_chg, first, accept, last, out_free;
  logic       load_new, load_held, hold_new, acc_wr;

  always_comb begin
    // A mode switch mid-block drops the partial; this cycle's byte becomes byte 0.
    mode_chg = enable && (cnt_q != 4'd0) && (gen_speed != gen_q);
    eff_cnt  = mode_chg ? 4'd0 : cnt_q;
    first    = (eff_cnt == 4'd0);
    cur_type = first ? (d_sel == TDSEL) : type_q;
    // Past byte 0 gen_speed equals gen_q (otherwise mode_chg), so gen_speed
    // is the mode of whatever is being accepted.
    case (gen_speed)
      2'd1:    blk_last = 4'd15;
      2'd2:    blk_last = 4'd7;
      default: blk_last = 4'd0;
    endcase
    in_ready  = rst && enable && (gen_speed != 2'd3) && !acc_full_q;
    accept    = in_valid && in_ready && (d_sel != IDSEL);
    last      = (eff_cnt == blk_last);
    out_free  = !out_valid_q || out_ready;
    // in_ready is low while acc_full, so load_held never coincides with accept.
    load_held = enable && acc_full_q && out_free;
    load_new  = accept && last && out_free;
    hold_new  = accept && last && !out_free;
    acc_wr    = accept && !load_new;
    fmt_mode  = load_held ? gen_q  : gen_speed;
    fmt_type  = load_held ? type_q : cur_type;

    cnt_d = eff_cnt;
    if (!enable)     cnt_d = 4'd0;
    else if (accept) cnt_d = last ? 4'd0 : eff_cnt + 4'd1;

    gen_d  = gen_q;
    type_d = type_q;
    if (accept && first) begin
      gen_d  = gen_speed;
      type_d = cur_type;
    end

    acc_full_d = acc_full_q;
    if (!enable || load_held) acc_full_d = 1'b0;
    else if (hold_new)        acc_full_d = 1'b1;

    out_valid_d = out_valid_q;
    if (!enable)                    out_valid_d = 1'b0;
    else if (load_new || load_held) out_valid_d = 1'b1;
    else if (out_ready)             out_valid_d = 1'b0;

    out_type_d = out_type_q;
    if (load_new || load_held) out_type_d = fmt_type;

    new_sym_d    = load_new || load_held;
    enable_ser_d = enable && (enable_ser_q || load_new || load_held);
    mode_err_d   = (in_valid && gen_speed == 2'd3) || mode_chg;
  end

  always_ff @(posedge enc_clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      gen_q        <= '0;
      type_q       <= 1'b0;
      acc_full_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_type_q   <= 1'b0;
      new_sym_q    <= 1'b0;
      enable_ser_q <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      gen_q        <= gen_d;
      type_q       <= type_d;
      acc_full_q   <= acc_full_d;
      out_valid_q  <= out_valid_d;
      out_type_q   <= out_type_d;
      new_sym_q    <= new_sym_d;
      enable_ser_q <= enable_ser_d;
      mode_err_q   <= mode_err_d;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    usb4_lbe_lane u_lane (
      .enc_clk      (enc_clk),
      .rst          (rst),
      .flush        (!enable),
      .byte_in      (lane_tx[8*k +: 8]),
      .first        (first),
      .pos          (eff_cnt),
      .acc_wr       (acc_wr),
      .out_ld       (load_new || load_held),
      .out_sel_held (load_held),
      .fmt_mode     (fmt_mode),
      .fmt_type     (fmt_type),
      .blk_out      (out_data[132*k +: 132])
    );
  end

  assign out_valid  = out_valid_q;
  assign out_type   = out_type_q;
  assign new_sym    = new_sym_q;
  assign enable_ser = enable_ser_q;
  assign mode_err   = mode_err_q;
endmodule

// File: tb/tb_usb4_lane_block_encoder.sv
// Bench for usb4_lane_block_encoder: directed scenarios followed by a random
// phase, all checked every cycle against a block-level model (partial byte
// list plus a two-entry queue of completed blocks awaiting the serializer).
module tb_usb4_lane_block_encoder;
  localparam int NL = 2;
  localparam int W  = 132 * NL;

  logic          enc_clk, rst, enable, in_valid, in_ready, out_type, out_valid;
  logic          out_ready, new_sym, enable_ser, mode_err;
  logic [1:0]    gen_speed;
  logic [3:0]    d_sel;
  logic [8*NL-1:0] lane_tx;
  logic [W-1:0]  out_data;

  int checks = 0;
  int errors = 0;

  usb4_lane_block_encoder #(.NUM_LANES(NL), .TRANSPORT_DSEL(8), .IDLE_DSEL(9)) dut (
    .enc_clk(enc_clk), .rst(rst), .enable(enable), .gen_speed(gen_speed),
    .d_sel(d_sel), .in_valid(in_valid), .in_ready(in_ready), .lane_tx(lane_tx),
    .out_data(out_data), .out_type(out_type), .out_valid(out_valid),
    .out_ready(out_ready), .new_sym(new_sym), .enable_ser(enable_ser),
    .mode_err(mode_err)
  );

  initial enc_clk = 1'b0;
  always #5 enc_clk = ~enc_clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         typ;
    int           id;
  } blk_t;

  blk_t            fifo[$];
  logic [8*NL-1:0] pbytes[$];
  logic [1:0]      p_mode;
  logic            p_type;
  logic            m_new, m_ser, m_err, m_ir;
  int              next_id = 0;
  int              m_hb, m_blen;
  logic [W-1:0]    m_blk;

  always @(negedge enc_clk) begin
    if (!rst) begin
      fifo.delete(); pbytes.delete();
      m_new = 0; m_ser = 0; m_err = 0;
      chk("rst_status", W'({out_valid, new_sym, enable_ser, mode_err, out_type, in_ready}), '0);
      chk("rst_data", out_data, '0);
    end else begin
      m_ir = enable && gen_speed != 2'd3 && fifo.size() < 2;
      chk("in_ready", W'(in_ready), W'(m_ir));
      chk("out_valid", W'(out_valid), W'(fifo.size() > 0));
      if (fifo.size() > 0) begin
        chk("out_data", out_data, fifo[0].data);
        chk("out_type", W'(out_type), W'(fifo[0].typ));
      end
      chk("new_sym", W'(new_sym), W'(m_new));
      chk("enable_ser", W'(enable_ser), W'(m_ser));
      chk("mode_err", W'(mode_err), W'(m_err));

      // what the coming clock edge does to the model
      m_err = (in_valid && gen_speed == 2'd3) ||
              (enable && pbytes.size() > 0 && gen_speed != p_mode);
      if (!enable) begin
        fifo.delete(); pbytes.delete();
        m_new = 0; m_ser = 0;
      end else begin
        m_hb = (fifo.size() > 0) ? fifo[0].id : -1;
        if (pbytes.size() > 0 && gen_speed != p_mode) pbytes.delete();
        if (fifo.size() > 0 && out_ready) void'(fifo.pop_front());
        if (in_valid && m_ir && d_sel != 4'd9) begin
          if (pbytes.size() == 0) begin
            p_mode = gen_speed;
            p_type = (d_sel == 4'd8);
          end
          pbytes.push_back(lane_tx);
          m_blen = (p_mode == 2'd1) ? 16 : (p_mode == 2'd2) ? 8 : 1;
          if (pbytes.size() == m_blen) begin
            m_blk = '0;
            for (int k = 0; k < NL; k++) begin
              for (int n = 0; n < m_blen; n++) m_blk[132*k + 8*n +: 8] = pbytes[n][8*k +: 8];
              if (p_mode == 2'd1)      m_blk[132*k + 128 +: 4] = p_type ? 4'b0101 : 4'b1010;
              else if (p_mode == 2'd2) m_blk[132*k + 64 +: 2]  = p_type ? 2'b01 : 2'b10;
            end
            fifo.push_back('{data: m_blk, typ: p_type, id: next_id});
            next_id++;
            pbytes.delete();
          end
        end
        m_new = (fifo.size() > 0) && (fifo[0].id != m_hb);
        m_ser = m_ser || (fifo.size() > 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(posedge enc_clk); #1; end
  endtask

  // Present one lane vector until it is taken (bounded), then return 1 ns
  // after the accepting edge.
  task automatic send(input logic [8*NL-1:0] b, input logic [3:0] ds);
    int n;
    n = 0;
    lane_tx = b; d_sel = ds; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge enc_clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $error("FAIL send_timeout: observed in_ready=0 after %0d cycles expected 1", n);
    end
    @(posedge enc_clk); #1;
  endtask

  initial begin
    enable = 1'b1; gen_speed = 2'd2; d_sel = 4'd9; in_valid = 1'b0;
    lane_tx = '0; out_ready = 1'b1;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_status", W'({out_valid, new_sym, enable_ser, mode_err, out_type, in_ready}), '0);
    chk("reset_data", out_data, '0);
    cyc(3);
    rst = 1'b1;

    // 64b/66b transport block, both lanes
    for (int i = 0; i < 8; i++) send({8'(8'h80 + i), 8'(i)}, 4'd8);
    in_valid = 1'b0;
    chk("g2_valid_sym", W'({out_valid, new_sym, out_type}), W'(3'b111));
    chk("g2_lane0", W'(out_data[131:0]), W'({66'd0, 2'b01, 64'h0706050403020100}));
    chk("g2_lane1", W'(out_data[263:132]), W'({66'd0, 2'b01, 64'h8786858483828180}));
    cyc(1);

    // 128b/132b, header decided by byte 0 only
    gen_speed = 2'd1;
    for (int i = 0; i < 16; i++) send({8'(8'h20 + i), 8'(8'h10 + i)}, (i == 0) ? 4'd2 : 4'd8);
    in_valid = 1'b0;
    chk("g1_os_lane0", W'(out_data[131:0]),
        W'({4'b1010, 128'h1F1E1D1C1B1A19181716151413121110}));
    chk("g1_os_type", W'(out_type), '0);
    cyc(1);

    // Serializer stall: one block on the output, one held in the accumulator
    gen_speed = 2'd2; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send({8'(8'hC0 + i), 8'(8'h40 + i)}, 4'd8);
    lane_tx = {8'hD0, 8'h50}; d_sel = 4'd8; in_valid = 1'b1;
    #1;
    chk("stall_in_ready", W'(in_ready), '0);
    cyc(3);
    chk("stall_hold", W'(out_data[131:0]), W'({66'd0, 2'b01, 64'h4746454443424140}));
    out_ready = 1'b1;
    cyc(1);
    chk("held_move", W'({out_valid, new_sym}), W'(2'b11));
    chk("held_lane0", W'(out_data[131:0]), W'({66'd0, 2'b01, 64'h4F4E4D4C4B4A4948}));
    chk("held_ready", W'(in_ready), W'(1));
    for (int i = 16; i < 24; i++) send({8'(8'hC0 + i), 8'(8'h40 + i)}, 4'd8);
    in_valid = 1'b0;
    chk("third_lane0", W'(out_data[131:0]), W'({66'd0, 2'b01, 64'h5756555453525150}));
    cyc(1);

    // Mode change mid-block
    for (int i = 0; i < 3; i++) send({8'hE0, 8'(8'h60 + i)}, 4'd8);
    gen_speed = 2'd1;
    send({8'hF0, 8'h70}, 4'd8);
    chk("mode_err_pulse", W'(mode_err), W'(1));
    for (int i = 1; i < 16; i++) begin
      send({8'(8'hF0 + i), 8'(8'h70 + i)}, 4'd8);
      if (i == 1) chk("mode_err_clear", W'(mode_err), '0);
    end
    in_valid = 1'b0;
    chk("modechg_lane0", W'(out_data[131:0]),
        W'({4'b0101, 128'h7F7E7D7C7B7A79787776757473727170}));
    cyc(1);

    // Gen4 pass-through, then flush via enable
    gen_speed = 2'd0;
    send({8'h11, 8'hA5}, 4'd8);
    chk("g0_first", W'({out_valid, enable_ser, out_type}), W'(3'b111));
    chk("g0_byte0", W'(out_data[131:0]), W'(8'hA5));
    send({8'h22, 8'h5A}, 4'd2);
    chk("g0_second", W'({out_valid, new_sym, out_type}), W'(3'b110));
    chk("g0_byte1", W'(out_data[131:0]), W'(8'h5A));
    in_valid = 1'b0; enable = 1'b0;
    cyc(1);
    chk("flush", W'({out_valid, enable_ser, in_ready}), '0);
    enable = 1'b1;

    // Reserved mode
    gen_speed = 2'd3; in_valid = 1'b1;
    #1;
    chk("g3_ready", W'(in_ready), '0);
    cyc(1);
    chk("g3_err", W'(mode_err), W'(1));
    in_valid = 1'b0;
    cyc(1);
    chk("g3_err_clear", W'(mode_err), '0);
    gen_speed = 2'd2;
    cyc(1);

    // Idle bytes interleaved
    for (int j = 0; j < 16; j++) begin
      if (j % 2 == 0) send({8'hEE, 8'hEE}, 4'd9);
      else            send({8'(8'hB0 + j / 2), 8'(8'h30 + j / 2)}, 4'd8);
    end
    in_valid = 1'b0;
    chk("idle_lane0", W'(out_data[131:0]), W'({66'd0, 2'b01, 64'h3736353433323130}));
    cyc(1);

    // Reset mid-block
    for (int i = 0; i < 3; i++) send({8'h99, 8'(8'h90 + i)}, 4'd8);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rstmid_status", W'({out_valid, new_sym, enable_ser, mode_err, out_type, in_ready}), '0);
    chk("rstmid_data", out_data, '0);
    cyc(2);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) send({8'hAA, 8'(8'hA0 + i)}, 4'd8);
    in_valid = 1'b0;
    chk("post_rst_lane0", W'(out_data[131:0]), W'({66'd0, 2'b01, 64'hA7A6A5A4A3A2A1A0}));
    cyc(1);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      in_valid  = ($urandom_range(0, 3) != 0);
      lane_tx   = 16'($urandom);
      r         = $urandom_range(0, 7);
      d_sel     = (r < 4) ? 4'd8 : (r < 6) ? 4'd9 : 4'($urandom_range(0, 15));
      out_ready = (c % 200 < 30) ? 1'b0 : ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 49) == 0) gen_speed = 2'($urandom_range(0, 2));
      else if ($urandom_range(0, 299) == 0) gen_speed = 2'd3;
      cyc(1);
    end
    in_valid = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
